// File: rtl/wb_arbiter.sv
// Writeback arbiter: one request buffer each for the execute and load units,
// round-robin grant to the register-file write port, and a pending-write scoreboard.
module wb_arbiter #(
  parameter int   XLEN    = 32,
  parameter logic RR_INIT = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            EX_VALID,
  input  logic [4:0]      EX_RD,
  input  logic [XLEN-1:0] EX_DATA,
  output logic            EX_READY,
  input  logic            LD_VALID,
  input  logic [4:0]      LD_RD,
  input  logic [XLEN-1:0] LD_DATA,
  output logic            LD_READY,
  input  logic            ISSUE_VALID,
  input  logic [4:0]      ISSUE_RD,
  input  logic [4:0]      RS1,
  input  logic [4:0]      RS2,
  output logic            RS1_BUSY,
  output logic            RS2_BUSY,
  output logic            RF_WE,
  output logic [4:0]      RF_WADDR,
  output logic [XLEN-1:0] RF_WDATA
);

  typedef enum logic [1:0] {GNT_NONE, GNT_EX, GNT_LD} grant_e;

  logic            ex_full, ld_full;
  logic [4:0]      ex_rd, ld_rd;
  logic [XLEN-1:0] ex_data, ld_data;
  logic            rr_last;  // 0: EX granted last, 1: LD granted last
  logic [31:0]     pending, pending_nxt;
  grant_e          grant;
  logic            ex_accept, ld_accept;

  // NOTE: every variable assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = GNT_NONE;
    if (ex_full && ld_full) grant = rr_last ? GNT_EX : GNT_LD;
    else if (ex_full)       grant = GNT_EX;
    else if (ld_full)       grant = GNT_LD;
  end

  // A buffer can take a new request in the same cycle it drains to the RF.
  assign EX_READY  = !RST && (!ex_full || (grant == GNT_EX));
  assign LD_READY  = !RST && (!ld_full || (grant == GNT_LD));
  assign ex_accept = EX_VALID && EX_READY;
  assign ld_accept = LD_VALID && LD_READY;

  always_comb begin
    RF_WE    = 1'b0;
    RF_WADDR = '0;
    RF_WDATA = '0;
    case (grant)
      GNT_EX: begin
        RF_WE    = (ex_rd != 5'd0);
        RF_WADDR = ex_rd;
        RF_WDATA = ex_data;
      end
      GNT_LD: begin
        RF_WE    = (ld_rd != 5'd0);
        RF_WADDR = ld_rd;
        RF_WDATA = ld_data;
      end
      default: ;
    endcase
  end

  // A same-cycle issue to the register being written leaves it pending.
  always_comb begin
    pending_nxt = pending;
    if (RF_WE) pending_nxt[RF_WADDR] = 1'b0;
    if (ISSUE_VALID && (ISSUE_RD != 5'd0)) pending_nxt[ISSUE_RD] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign RS1_BUSY = pending[RS1];
  assign RS2_BUSY = pending[RS2];

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_full <= 1'b0;
      ld_full <= 1'b0;
      rr_last <= RR_INIT;
      pending <= '0;
    end else begin
      if (ex_accept)             ex_full <= 1'b1;
      else if (grant == GNT_EX)  ex_full <= 1'b0;
      if (ld_accept)             ld_full <= 1'b1;
      else if (grant == GNT_LD)  ld_full <= 1'b0;
      if (grant != GNT_NONE)     rr_last <= (grant == GNT_LD);
      pending <= pending_nxt;
    end
  end

  // NOTE: payload registers are not reset; they are only observed while the matching full flag is set.
  always_ff @(posedge CLK) begin
    if (ex_accept) begin
      ex_rd   <= EX_RD;
      ex_data <= EX_DATA;
    end
    if (ld_accept) begin
      ld_rd   <= LD_RD;
      ld_data <= LD_DATA;
    end
  end

endmodule
